// File: rtl/neuron_backward.sv
// Backward pass of a single ReLU neuron: gates dy by the forward pre-activation and
// streams per-element gradients dw[k]=g*x[k], dx[k]=g*w[k], then reports db=g.
module neuron_backward #(
  parameter int N     = 4,
  parameter int WIDTH = 8,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1,
  localparam int PW    = 2 * WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N*WIDTH-1:0]       x_flat,
  input  logic [N*WIDTH-1:0]       w_flat,
  input  logic signed [PW+1:0]     z,
  input  logic signed [WIDTH-1:0]  dy,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [IDX_W-1:0]         out_idx,
  output logic signed [PW-1:0]     dw,
  output logic signed [PW-1:0]     dx,
  output logic signed [WIDTH-1:0]  db,
  output logic                     done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  state_t                  r_state;
  logic                    r_in_ready;
  logic [IDX_W-1:0]        r_k;
  logic signed [WIDTH-1:0] r_g;
  logic signed [WIDTH-1:0] r_x [N];
  logic signed [WIDTH-1:0] r_w [N];

  logic signed [WIDTH-1:0] w_g;
  logic [IDX_W-1:0]        w_k_nxt;

  // Full-precision product; (-2^(W-1))^2 still fits in 2W signed bits.
  function automatic logic signed [PW-1:0] smul(input logic signed [WIDTH-1:0] a,
                                                input logic signed [WIDTH-1:0] b);
    return PW'(a) * PW'(b);
  endfunction

  function automatic logic signed [WIDTH-1:0] elem(input logic [N*WIDTH-1:0] f,
                                                   input int k);
    return $signed(f[k*WIDTH +: WIDTH]);
  endfunction

  // ReLU derivative: strictly positive z passes dy, z <= 0 blocks it.
  assign w_g      = (!z[PW+1] && (z != '0)) ? dy : '0;
  assign w_k_nxt  = r_k + 1'b1;
  assign in_ready = r_in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_in_ready <= 1'b0;
      r_k        <= '0;
      r_g        <= '0;
      out_valid  <= 1'b0;
      out_idx    <= '0;
      dw         <= '0;
      dx         <= '0;
      db         <= '0;
      done       <= 1'b0;
      for (int i = 0; i < N; i++) begin
        r_x[i] <= '0;
        r_w[i] <= '0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          done       <= 1'b0;
          db         <= '0;
          r_in_ready <= 1'b1;
          if (in_valid && r_in_ready) begin
            for (int i = 0; i < N; i++) begin
              r_x[i] <= elem(x_flat, i);
              r_w[i] <= elem(w_flat, i);
            end
            r_g        <= w_g;
            r_k        <= '0;
            out_idx    <= '0;
            dw         <= smul(w_g, elem(x_flat, 0));
            dx         <= smul(w_g, elem(w_flat, 0));
            out_valid  <= 1'b1;
            r_in_ready <= 1'b0;
            r_state    <= RUN;
          end
        end
        // ---- beat stream: outputs advance only on an accepted beat
        RUN: begin
          if (out_ready) begin
            if (r_k == LAST) begin
              out_valid <= 1'b0;
              out_idx   <= '0;
              dw        <= '0;
              dx        <= '0;
              done      <= 1'b1;
              db        <= r_g;
              r_state   <= DONE;
            end else begin
              r_k     <= w_k_nxt;
              out_idx <= w_k_nxt;
              dw      <= smul(r_g, r_x[w_k_nxt]);
              dx      <= smul(r_g, r_w[w_k_nxt]);
            end
          end
        end
        // ---- completion pulse, then back to accepting jobs
        DONE: begin
          done       <= 1'b0;
          db         <= '0;
          r_in_ready <= 1'b1;
          r_state    <= IDLE;
        end
        default: begin
          r_state    <= IDLE;
          r_in_ready <= 1'b0;
          out_valid  <= 1'b0;
          done       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_backward.sv
// Directed bench for neuron_backward: each task drives one scenario and checks inline.
module tb_neuron_backward;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [31:0]        x_flat;
  logic [31:0]        w_flat;
  logic signed [17:0] z;
  logic signed [7:0]  dy;
  logic               out_valid;
  logic               out_ready;
  logic [1:0]         out_idx;
  logic signed [15:0] dw;
  logic signed [15:0] dx;
  logic signed [7:0]  db;
  logic               done;

  int checks = 0;
  int errors = 0;

  neuron_backward #(.N(4), .WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x_flat(x_flat), .w_flat(w_flat), .z(z), .dy(dy),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .dw(dw), .dx(dx), .db(db), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] pack4(input int a, input int b, input int c, input int d);
    return {d[7:0], c[7:0], b[7:0], a[7:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for in_ready, present a job for exactly one accepting edge.
  task automatic offer(input logic [31:0] xf, input logic [31:0] wf,
                       input int zv, input int dyv);
    int n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL offer_ready: in_ready=%b, required 1 within 20 cycles", in_ready);
    end
    x_flat   = xf;
    w_flat   = wf;
    z        = 18'(zv);
    dy       = 8'(dyv);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    x_flat   = '0;
    w_flat   = '0;
    z        = '0;
    dy       = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0 ||
        out_idx !== 2'd0 || dw !== 16'sd0 || dx !== 16'sd0 || db !== 8'sd0) begin
      errors++;
      $display("FAIL reset_state: rdy=%b ov=%b done=%b idx=%0d dw=%0d dx=%0d db=%0d, required all 0",
               in_ready, out_valid, done, out_idx, dw, dx, db);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: in_ready=%b, required 1", in_ready);
    end
  endtask

  task automatic test_basic();
    int edw [4] = '{3, 6, 9, 12};
    offer(pack4(1, 2, 3, 4), pack4(1, 1, 1, 1), 15, 3);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (out_valid !== 1'b1 || out_idx !== 2'(k) || dw !== 16'(edw[k]) || dx !== 16'sd3) begin
        errors++;
        $display("FAIL basic_beat%0d: ov=%b idx=%0d dw=%0d dx=%0d, required 1 %0d %0d 3",
                 k, out_valid, out_idx, dw, dx, k, edw[k]);
      end
      tick();
    end
    checks++;
    if (done !== 1'b1 || db !== 8'sd3 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_done: done=%b db=%0d ov=%b rdy=%b, required 1 3 0 0",
               done, db, out_valid, in_ready);
    end
    tick();
    checks++;
    if (in_ready !== 1'b1 || done !== 1'b0 || db !== 8'sd0) begin
      errors++;
      $display("FAIL basic_idle: rdy=%b done=%b db=%0d, required 1 0 0", in_ready, done, db);
    end
  endtask

  task automatic test_gated();
    int zs [2] = '{-9, 0};
    for (int j = 0; j < 2; j++) begin
      offer(pack4(2, 2, 2, 2), pack4(-1, -1, -1, -1), zs[j], 5);
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (out_valid !== 1'b1 || out_idx !== 2'(k) || dw !== 16'sd0 || dx !== 16'sd0) begin
          errors++;
          $display("FAIL gated_z%0d_beat%0d: ov=%b idx=%0d dw=%0d dx=%0d, required 1 %0d 0 0",
                   zs[j], k, out_valid, out_idx, dw, dx, k);
        end
        tick();
      end
      checks++;
      if (done !== 1'b1 || db !== 8'sd0) begin
        errors++;
        $display("FAIL gated_z%0d_done: done=%b db=%0d, required 1 0", zs[j], done, db);
      end
      tick();
    end
  endtask

  task automatic test_mixed();
    int edw [4] = '{-10, 6, -4, -2};
    offer(pack4(5, -3, 2, 1), pack4(2, 2, 2, 2), 13, -2);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (out_valid !== 1'b1 || out_idx !== 2'(k) || dw !== 16'(edw[k]) || dx !== -16'sd4) begin
        errors++;
        $display("FAIL mixed_beat%0d: ov=%b idx=%0d dw=%0d dx=%0d, required 1 %0d %0d -4",
                 k, out_valid, out_idx, dw, dx, k, edw[k]);
      end
      tick();
    end
    checks++;
    if (done !== 1'b1 || db !== -8'sd2) begin
      errors++;
      $display("FAIL mixed_done: done=%b db=%0d, required 1 -2", done, db);
    end
    tick();
  endtask

  task automatic test_backpressure();
    int edw [4] = '{-10, 6, -4, -2};
    int cyc = 0;
    offer(pack4(5, -3, 2, 1), pack4(2, 2, 2, 2), 13, -2);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (out_valid !== 1'b1 || out_idx !== 2'(k) || dw !== 16'(edw[k]) || dx !== -16'sd4) begin
        errors++;
        $display("FAIL bp_beat%0d: ov=%b idx=%0d dw=%0d dx=%0d, required 1 %0d %0d -4",
                 k, out_valid, out_idx, dw, dx, k, edw[k]);
      end
      if (k == 1) begin
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          tick();
          cyc++;
          checks++;
          if (out_valid !== 1'b1 || out_idx !== 2'd1 || dw !== 16'sd6 || dx !== -16'sd4 || done !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold%0d: ov=%b idx=%0d dw=%0d dx=%0d done=%b, required 1 1 6 -4 0",
                     s, out_valid, out_idx, dw, dx, done);
          end
        end
        out_ready = 1'b1;
      end
      tick();
      cyc++;
    end
    checks++;
    if (done !== 1'b1 || db !== -8'sd2 || cyc !== 7) begin
      errors++;
      $display("FAIL bp_done: done=%b db=%0d cycles=%0d, required 1 -2 7", done, db, cyc);
    end
    tick();
  endtask

  task automatic test_extremes();
    offer(pack4(-128, 0, 0, 0), pack4(127, 0, 0, 0), 1, -128);
    checks++;
    if (out_valid !== 1'b1 || out_idx !== 2'd0 || dw !== 16'sd16384 || dx !== -16'sd16256) begin
      errors++;
      $display("FAIL extreme_beat0: ov=%b idx=%0d dw=%0d dx=%0d, required 1 0 16384 -16256",
               out_valid, out_idx, dw, dx);
    end
    for (int k = 1; k < 4; k++) begin
      tick();
      checks++;
      if (out_idx !== 2'(k) || dw !== 16'sd0 || dx !== 16'sd0) begin
        errors++;
        $display("FAIL extreme_beat%0d: idx=%0d dw=%0d dx=%0d, required %0d 0 0", k, out_idx, dw, dx, k);
      end
    end
    tick();
    checks++;
    if (done !== 1'b1 || db !== -8'sd128) begin
      errors++;
      $display("FAIL extreme_done: done=%b db=%0d, required 1 -128", done, db);
    end
    tick();
  endtask

  task automatic test_reset_midrun();
    int edw [4] = '{3, 6, 9, 12};
    offer(pack4(1, 2, 3, 4), pack4(1, 1, 1, 1), 15, 3);
    tick();
    tick();
    checks++;
    if (out_idx !== 2'd2 || dw !== 16'sd9) begin
      errors++;
      $display("FAIL midrun_k2: idx=%0d dw=%0d, required 2 9", out_idx, dw);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || done !== 1'b0 || out_idx !== 2'd0 ||
        dw !== 16'sd0 || dx !== 16'sd0 || db !== 8'sd0) begin
      errors++;
      $display("FAIL midrun_abort: ov=%b done=%b idx=%0d dw=%0d dx=%0d db=%0d, required all 0",
               out_valid, done, out_idx, dw, dx, db);
    end
    tick();
    checks++;
    if (in_ready !== 1'b1 || done !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrun_idle: rdy=%b done=%b ov=%b, required 1 0 0", in_ready, done, out_valid);
    end
    offer(pack4(1, 2, 3, 4), pack4(1, 1, 1, 1), 15, 3);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (out_valid !== 1'b1 || out_idx !== 2'(k) || dw !== 16'(edw[k]) || dx !== 16'sd3) begin
        errors++;
        $display("FAIL midrun_rejob_beat%0d: ov=%b idx=%0d dw=%0d dx=%0d, required 1 %0d %0d 3",
                 k, out_valid, out_idx, dw, dx, k, edw[k]);
      end
      tick();
    end
    checks++;
    if (done !== 1'b1 || db !== 8'sd3) begin
      errors++;
      $display("FAIL midrun_rejob_done: done=%b db=%0d, required 1 3", done, db);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int n = 1;
    offer(pack4(1, 1, 1, 1), pack4(1, 1, 1, 1), 4, 1);
    while (in_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 6) begin
      errors++;
      $display("FAIL turnaround: accept-to-accept=%0d cycles, required 6", n);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    x_flat    = '0;
    w_flat    = '0;
    z         = '0;
    dy        = '0;
    test_reset();
    test_basic();
    test_gated();
    test_mixed();
    test_backpressure();
    test_extremes();
    test_reset_midrun();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
